// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC, single outstanding fetch, static next-PC prediction
// Hands fetched words to decode; flush/jump_flush redirect the PC and drop wrong-path data.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_dnpc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] inst_q, inst_d;

  logic        redir;
  logic [31:0] target;
  logic [4:0]  op;
  logic [31:0] jal_imm;
  logic [31:0] br_imm;
  logic [31:0] pred_pc;

  assign redir  = flush | jump_flush;
  assign target = flush ? flush_dnpc : jump_dnpc;

  assign op      = resp_data[6:2];
  assign jal_imm = {{11{resp_data[31]}}, resp_data[31], resp_data[19:12], resp_data[20],
                    resp_data[30:21], 1'b0};
  assign br_imm  = {{19{resp_data[31]}}, resp_data[31], resp_data[7], resp_data[30:25],
                    resp_data[11:8], 1'b0};

  // Static prediction: JAL and backward branches taken, all else (JALR included) falls through.
  always_comb begin
    pred_pc = pc_q + 32'd4;
    if (op == 5'b11011) begin
      pred_pc = pc_q + jal_imm;
    end else if ((op == 5'b11000) && resp_data[31]) begin
      pred_pc = pc_q + br_imm;
    end
    pred_pc[0] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    inst_d    = inst_q;
    req_valid = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_REQ: begin
        // Gated by the reset input so no request is visible while reset is held.
        req_valid = reset;
        if (redir) begin
          pc_d = target;
          if (req_ready) state_d = S_DROP;
        end else if (req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_d    = target;
          state_d = resp_valid ? S_REQ : S_DROP;
        end else if (resp_valid) begin
          inst_d  = resp_data;
          npc_d   = pred_pc;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = ~redir;
        if (redir) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = npc_q;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // One response is still owed for a request issued on the wrong path.
        if (redir) pc_d = target;
        if (resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      inst_q  <= inst_d;
    end
  end

  assign req_addr = {pc_q[31:2], 2'b00};
  assign out_pc   = pc_q;
  assign out_inst = inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed bench for ifu_fetch
// One-cycle memory model plus hand-driven stale responses.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JAL16  = 32'h0100_006F;
  localparam logic [31:0] BEQM4  = 32'hFE00_0EE3;
  localparam logic [31:0] SEQ_ADDR [6] = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008,
                                           32'h3000_000C, 32'h3000_0010, 32'h3000_0020};
  localparam logic [31:0] SEQ_INST [6] = '{NOP, NOP, NOP, NOP, JAL16, BEQM4};

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] flush_dnpc;
  logic        jump_flush;
  logic [31:0] jump_dnpc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  logic        mem_auto;
  logic        auto_valid;
  logic [31:0] auto_data;
  logic        man_valid;
  logic [31:0] man_data;
  logic        fire;
  logic [31:0] faddr;

  int checks;
  int errors;

  assign resp_valid = auto_valid | man_valid;
  assign resp_data  = auto_valid ? auto_data : man_data;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .flush_dnpc (flush_dnpc),
    .jump_flush (jump_flush),
    .jump_dnpc  (jump_dnpc),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h3000_0010: return JAL16;
      32'h3000_0020: return BEQM4;
      default:       return NOP;
    endcase
  endfunction

  // Memory answers one cycle after each accepted request.
  initial begin
    auto_valid = 1'b0;
    auto_data  = 32'h0;
    forever begin
      @(negedge clock);
      fire  = mem_auto && req_valid && req_ready;
      faddr = req_addr;
      @(posedge clock);
      #1;
      auto_valid = fire;
      auto_data  = mem_word(faddr);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (req_addr !== RST_PC) begin errors++; $display("FAIL rst_req_addr: got %h want %h", req_addr, RST_PC); end
    checks++; if (out_pc !== RST_PC) begin errors++; $display("FAIL rst_out_pc: got %h want %h", out_pc, RST_PC); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_inst: got %h want 0", out_inst); end
    mem_auto  = 1'b1;
    req_ready = 1'b1;
    out_ready = 1'b1;
    reset     = 1'b1;
    #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL rel_req_valid: got %b want 1", req_valid); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 18; i++) begin
      int f;
      f = i / 3;
      case (i % 3)
        0: begin
          checks++;
          if (req_valid !== 1'b1 || req_addr !== SEQ_ADDR[f] || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_req[%0d]: got v=%b addr=%h ov=%b want v=1 addr=%h ov=0", i, req_valid, req_addr, out_valid, SEQ_ADDR[f]);
          end
        end
        1: begin
          checks++;
          if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_wait[%0d]: got v=%b ov=%b want 0 0", i, req_valid, out_valid);
          end
        end
        default: begin
          checks++;
          if (out_valid !== 1'b1 || out_pc !== SEQ_ADDR[f] || out_inst !== SEQ_INST[f]) begin
            errors++;
            $display("FAIL seq_out[%0d]: got ov=%b pc=%h inst=%h want 1 %h %h", i, out_valid, out_pc, out_inst, SEQ_ADDR[f], SEQ_INST[f]);
          end
        end
      endcase
      step();
    end
  endtask

  task automatic test_hold_stall();
    out_ready = 1'b0;
    checks++; if (req_addr !== 32'h3000_001C) begin errors++; $display("FAIL bwd_branch_addr: got %h want 3000001c", req_addr); end
    step();
    step();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3000_001C || out_inst !== NOP || req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got ov=%b pc=%h inst=%h rv=%b want 1 3000001c %h 0", k, out_valid, out_pc, out_inst, req_valid, NOP);
      end
      if (k < 5) step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h3000_0020) begin errors++; $display("FAIL stall_release: got v=%b addr=%h want 1 30000020", req_valid, req_addr); end
  endtask

  task automatic test_jump_in_wait();
    mem_auto = 1'b0;
    step();
    jump_flush = 1'b1;
    jump_dnpc  = 32'h3000_0100;
    #1;
    checks++; if (out_valid !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL jw_wait: got ov=%b rv=%b want 0 0", out_valid, req_valid); end
    step();
    jump_flush = 1'b0;
    man_valid  = 1'b1;
    man_data   = NOP;
    #1;
    checks++; if (out_valid !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL jw_drop: got ov=%b rv=%b want 0 0", out_valid, req_valid); end
    step();
    man_valid = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h3000_0100 || out_valid !== 1'b0) begin errors++; $display("FAIL jw_redirect: got v=%b addr=%h ov=%b want 1 30000100 0", req_valid, req_addr, out_valid); end
  endtask

  task automatic test_flush_priority();
    mem_auto = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000_0100) begin errors++; $display("FAIL fp_hold: got ov=%b pc=%h want 1 30000100", out_valid, out_pc); end
    flush      = 1'b1;
    flush_dnpc = 32'h3000_0200;
    jump_flush = 1'b1;
    jump_dnpc  = 32'h3000_0100;
    out_ready  = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fp_gate: got ov=%b want 0", out_valid); end
    step();
    flush      = 1'b0;
    jump_flush = 1'b0;
    req_ready  = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h3000_0200) begin errors++; $display("FAIL fp_target: got v=%b addr=%h want 1 30000200", req_valid, req_addr); end
  endtask

  task automatic test_wrap();
    jump_flush = 1'b1;
    jump_dnpc  = 32'hFFFF_FFFC;
    step();
    jump_flush = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redir: got v=%b addr=%h want 1 fffffffc", req_valid, req_addr); end
    step();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_stable: got v=%b addr=%h want 1 fffffffc", req_valid, req_addr); end
    req_ready = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_inst !== NOP) begin errors++; $display("FAIL wrap_out: got ov=%b pc=%h inst=%h want 1 fffffffc %h", out_valid, out_pc, out_inst, NOP); end
    step();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got v=%b addr=%h want 1 00000000", req_valid, req_addr); end
  endtask

  task automatic test_reset_mid_wait();
    step();
    reset     = 1'b0;
    req_ready = 1'b0;
    mem_auto  = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b0 || out_valid !== 1'b0 || req_addr !== RST_PC || out_inst !== 32'h0) begin errors++; $display("FAIL mid_rst: got rv=%b ov=%b addr=%h inst=%h want 0 0 %h 0", req_valid, out_valid, req_addr, out_inst, RST_PC); end
    step();
    step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      man_valid = (k % 2 == 0);
      man_data  = JAL16;
      #1;
      checks++;
      if (out_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== RST_PC) begin
        errors++;
        $display("FAIL stale_resp[%0d]: got ov=%b rv=%b addr=%h want 0 1 %h", k, out_valid, req_valid, req_addr, RST_PC);
      end
      step();
    end
    man_valid = 1'b0;
    req_ready = 1'b1;
    mem_auto  = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== RST_PC || out_inst !== NOP) begin errors++; $display("FAIL post_rst_fetch: got ov=%b pc=%h inst=%h want 1 %h %h", out_valid, out_pc, out_inst, RST_PC, NOP); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    flush      = 1'b0;
    flush_dnpc = 32'h0;
    jump_flush = 1'b0;
    jump_dnpc  = 32'h0;
    req_ready  = 1'b0;
    out_ready  = 1'b0;
    mem_auto   = 1'b0;
    man_valid  = 1'b0;
    man_data   = 32'h0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_jump_in_wait();
    test_flush_priority();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
